// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-sense constants.
// Used by both the receive and transmit engines.
package uart_pkg;

  localparam int UART_STATE_W = 3;

  typedef enum logic [UART_STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Value XORed into the data parity to form the expected parity bit.
  localparam logic UART_PARITY_EVEN = 1'b0;
  localparam logic UART_PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous pad inputs; flops reset to 1 (idle line).
// Latency: two clk cycles; no backpressure.
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign d_out = sync_q;

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: oversampled start detect, mid-bit sampling, parity and stop checks.
// rx_valid pulses one cycle after the tick that samples the final stop bit; no backpressure.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  rx_clk,
  input  logic                  resetn,
  input  logic                  sample_tick,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_SENSE = (PARITY_ODD != 0) ? UART_PARITY_ODD
                                                              : UART_PARITY_EVEN;

  logic rx_s;

  uart_rx_sync #(
    .WIDTH (1)
  ) u_sync (
    .clk    (rx_clk),
    .resetn (resetn),
    .d_in   (rx_in),
    .d_out  (rx_s)
  );

  uart_state_e           state_q, state_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  armed_q, armed_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;

  logic mid_bit;
  logic ferr_now;

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    armed_d      = armed_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    mid_bit  = sample_tick && (tick_cnt_q == TICK_FULL);
    ferr_now = ferr_q | ~rx_s;

    // Bit-period states count ticks until the next mid-bit sample point.
    if (sample_tick && (state_q == ST_DATA || state_q == ST_PARITY || state_q == ST_STOP)) begin
      tick_cnt_d = mid_bit ? '0 : tick_cnt_q + TICK_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // A falling edge only counts after a high has been seen, so a held-low line never retriggers.
        if (sample_tick) begin
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
            armed_d    = 1'b0;
          end
        end
      end

      ST_START: begin
        if (sample_tick) begin
          if (tick_cnt_q == TICK_HALF) begin
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d    = ST_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              perr_d     = 1'b0;
              ferr_d     = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (mid_bit) begin
          shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (mid_bit) begin
          perr_d    = rx_s ^ (^shift_q) ^ PAR_SENSE;
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end
      end

      ST_STOP: begin
        if (mid_bit) begin
          ferr_d = ferr_now;
          if (bit_cnt_q == STOP_LAST) begin
            rx_data_d    = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_now;
            rx_valid_d   = 1'b1;
            armed_d      = rx_s;
            bit_cnt_d    = '0;
            state_d      = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      armed_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  // The FSM is already back in IDLE during the rx_valid cycle; keep busy up through it.
  assign busy       = (state_q != ST_IDLE) || rx_valid_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: three instances (8N1, 8E1, 8N2), one serial line each.
module tb_uart_rx_engine;

  localparam int OS = 16;

  logic       rx_clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sample_tick = 1'b0;
  logic [2:0] rx_line = 3'b111;

  logic [7:0] rx_data_o [0:2];
  logic [2:0] rx_valid_o;
  logic [2:0] perr_o;
  logic [2:0] ferr_o;
  logic [2:0] busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int vcnt [0:2];
  int v0;

  always #5 rx_clk = ~rx_clk;

  uart_rx_engine #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .rx_clk(rx_clk), .resetn(resetn), .sample_tick(sample_tick), .rx_in(rx_line[0]),
    .rx_data(rx_data_o[0]), .rx_valid(rx_valid_o[0]), .parity_err(perr_o[0]),
    .frame_err(ferr_o[0]), .busy(busy_o[0]));

  uart_rx_engine #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .rx_clk(rx_clk), .resetn(resetn), .sample_tick(sample_tick), .rx_in(rx_line[1]),
    .rx_data(rx_data_o[1]), .rx_valid(rx_valid_o[1]), .parity_err(perr_o[1]),
    .frame_err(ferr_o[1]), .busy(busy_o[1]));

  uart_rx_engine #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .rx_clk(rx_clk), .resetn(resetn), .sample_tick(sample_tick), .rx_in(rx_line[2]),
    .rx_data(rx_data_o[2]), .rx_valid(rx_valid_o[2]), .parity_err(perr_o[2]),
    .frame_err(ferr_o[2]), .busy(busy_o[2]));

  // Count cycles with rx_valid high per instance; a one-cycle pulse adds exactly one.
  initial begin
    for (int i = 0; i < 3; i++) vcnt[i] = 0;
    forever begin
      @(negedge rx_clk);
      for (int i = 0; i < 3; i++) if (rx_valid_o[i]) vcnt[i] = vcnt[i] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One sample tick every two clocks, driven on falling edges.
  task automatic step();
    @(negedge rx_clk);
    sample_tick = 1'b1;
    @(negedge rx_clk);
    sample_tick = 1'b0;
  endtask

  task automatic send_bit(input int ln, input logic b);
    rx_line[ln] = b;
    repeat (OS) step();
  endtask

  task automatic send_frame(input int ln, input logic [7:0] data, input bit has_par,
                            input logic par, input bit two_stop, input logic stop2);
    send_bit(ln, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(ln, data[i]);
    if (has_par) send_bit(ln, par);
    send_bit(ln, 1'b1);
    if (two_stop) send_bit(ln, stop2);
    send_bit(ln, 1'b1);
    send_bit(ln, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge rx_clk);
    check_eq("rst_valid", {29'd0, rx_valid_o}, 32'd0);
    check_eq("rst_busy", {29'd0, busy_o}, 32'd0);
    check_eq("rst_perr", {29'd0, perr_o}, 32'd0);
    check_eq("rst_ferr", {29'd0, ferr_o}, 32'd0);
    check_eq("rst_data", {24'd0, rx_data_o[0]}, 32'd0);
    resetn = 1'b1;
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);

    // 8N1 0xA5
    v0 = vcnt[0];
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("a5_vcnt", vcnt[0] - v0, 32'd1);
    check_eq("a5_data", {24'd0, rx_data_o[0]}, 32'hA5);
    check_eq("a5_perr", {31'd0, perr_o[0]}, 32'd0);
    check_eq("a5_ferr", {31'd0, ferr_o[0]}, 32'd0);
    check_eq("a5_busy", {31'd0, busy_o[0]}, 32'd0);

    // 8E1 0x03 with wrong parity bit
    v0 = vcnt[1];
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("p03_vcnt", vcnt[1] - v0, 32'd1);
    check_eq("p03_data", {24'd0, rx_data_o[1]}, 32'h03);
    check_eq("p03_perr", {31'd0, perr_o[1]}, 32'd1);
    check_eq("p03_ferr", {31'd0, ferr_o[1]}, 32'd0);

    // False start: 5 low ticks
    v0 = vcnt[1];
    rx_line[1] = 1'b0;
    repeat (5) step();
    rx_line[1] = 1'b1;
    check_eq("fs_busy_hi", {31'd0, busy_o[1]}, 32'd1);
    send_bit(1, 1'b1);
    send_bit(1, 1'b1);
    check_eq("fs_busy_lo", {31'd0, busy_o[1]}, 32'd0);
    check_eq("fs_vcnt", vcnt[1] - v0, 32'd0);
    check_eq("fs_perr", {31'd0, perr_o[1]}, 32'd1);
    check_eq("fs_data", {24'd0, rx_data_o[1]}, 32'h03);

    // 8E1 0x07 with correct parity bit
    v0 = vcnt[1];
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("p07_vcnt", vcnt[1] - v0, 32'd1);
    check_eq("p07_data", {24'd0, rx_data_o[1]}, 32'h07);
    check_eq("p07_perr", {31'd0, perr_o[1]}, 32'd0);

    // 8N2 0x5A with bad second stop, then clean 0xFF
    v0 = vcnt[2];
    send_frame(2, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("s5a_vcnt", vcnt[2] - v0, 32'd1);
    check_eq("s5a_data", {24'd0, rx_data_o[2]}, 32'h5A);
    check_eq("s5a_ferr", {31'd0, ferr_o[2]}, 32'd1);
    v0 = vcnt[2];
    send_frame(2, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("sff_vcnt", vcnt[2] - v0, 32'd1);
    check_eq("sff_data", {24'd0, rx_data_o[2]}, 32'hFF);
    check_eq("sff_ferr", {31'd0, ferr_o[2]}, 32'd0);

    // Break: 40 bit times low on 8N1
    v0 = vcnt[0];
    rx_line[0] = 1'b0;
    repeat (40 * OS) step();
    check_eq("brk_vcnt", vcnt[0] - v0, 32'd1);
    check_eq("brk_data", {24'd0, rx_data_o[0]}, 32'h00);
    check_eq("brk_ferr", {31'd0, ferr_o[0]}, 32'd1);
    check_eq("brk_perr", {31'd0, perr_o[0]}, 32'd0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    check_eq("brk_vcnt_end", vcnt[0] - v0, 32'd1);

    // Reset after the 4th data bit of 0x3C
    v0 = vcnt[0];
    send_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, (i >= 2) ? 1'b1 : 1'b0);
    check_eq("mr_busy_pre", {31'd0, busy_o[0]}, 32'd1);
    resetn = 1'b0;
    @(negedge rx_clk);
    check_eq("mr_busy", {31'd0, busy_o[0]}, 32'd0);
    check_eq("mr_ferr", {31'd0, ferr_o[0]}, 32'd0);
    check_eq("mr_data", {24'd0, rx_data_o[1]}, 32'h00);
    check_eq("mr_valid", {29'd0, rx_valid_o}, 32'd0);
    rx_line[0] = 1'b1;
    resetn = 1'b1;
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    check_eq("mr_vcnt", vcnt[0] - v0, 32'd0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("r3c_vcnt", vcnt[0] - v0, 32'd1);
    check_eq("r3c_data", {24'd0, rx_data_o[0]}, 32'h3C);
    check_eq("r3c_ferr", {31'd0, ferr_o[0]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
